// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// Optional two's-complement operation is enabled by defining SIGNED_MULDIV_EN.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam int         CW     = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q;
   logic               dbz_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   opa_q;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   shifted;
   logic [WIDTH+1:0]   diff;
   logic               trial_neg;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   rem_fin;
   logic               accept;
   logic               div_zero;
   logic               last;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0]   quo_res;
   logic [WIDTH-1:0]   rem_res;

   assign accept   = start && (alu_control == OP_MUL || alu_control == OP_DIV);
   assign div_zero = (alu_control == OP_DIV) && (src_b == '0);
   assign last     = (cnt_q == CW'(WIDTH - 1));

   // Low half of the accumulator starts as the multiplier and is consumed LSB first.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? opa_q : {WIDTH{1'b0}})};
   assign acc_next = {mul_sum, acc_q[WIDTH-1:1]};

   assign shifted   = {rem_q, opa_q[WIDTH-1]};
   assign diff      = shifted - {2'b00, opb_q};
   assign trial_neg = diff[WIDTH+1];
   assign quo_next  = {opa_q[WIDTH-2:0], ~trial_neg};
   assign rem_fin   = trial_neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

`ifdef SIGNED_MULDIV_EN
   logic neg_q;
   logic neg_rem_q;

   assign mag_a    = src_a[WIDTH-1] ? -src_a : src_a;
   assign mag_b    = src_b[WIDTH-1] ? -src_b : src_b;
   assign prod_res = neg_q ? -acc_next : acc_next;
   assign quo_res  = neg_q ? -quo_next : quo_next;
   assign rem_res  = neg_rem_q ? -rem_fin : rem_fin;

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (state_q == IDLE && accept) begin
         neg_q     <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
         neg_rem_q <= src_a[WIDTH-1];
      end
   end
`else
   assign mag_a    = src_a;
   assign mag_b    = src_b;
   assign prod_res = acc_next;
   assign quo_res  = quo_next;
   assign rem_res  = rem_fin;
`endif

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      busy        = 1'b0;
      done        = 1'b0;
      div_by_zero = 1'b0;
      case (state_q)
         IDLE: if (accept) state_d = div_zero ? DONE : RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            done        = 1'b1;
            div_by_zero = dbz_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         dbz_q    <= 1'b0;
         acc_q    <= '0;
         rem_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  is_div_q <= (alu_control == OP_DIV);
                  dbz_q    <= div_zero;
                  cnt_q    <= '0;
                  opa_q    <= mag_a;
                  opb_q    <= mag_b;
                  acc_q    <= {{WIDTH{1'b0}}, mag_b};
                  rem_q    <= '0;
                  if (div_zero) begin
                     hi <= src_a;
                     lo <= '1;
                  end
               end
            end
            RUN: begin
               cnt_q <= cnt_q + CW'(1);
               if (is_div_q) begin
                  rem_q <= trial_neg ? shifted[WIDTH:0] : diff[WIDTH:0];
                  opa_q <= quo_next;
               end else begin
                  acc_q <= acc_next;
               end
               if (last) begin
                  if (is_div_q) begin
                     hi <= rem_res;
                     lo <= quo_res;
                  end else begin
                     {hi, lo} <= prod_res;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, random ops against an
// arithmetic reference model, and hand-written busy/ignore/reset sequences.
module tb_mul_div_unit;

   localparam int         W   = 32;
   localparam logic [2:0] MUL = 3'b101;
   localparam logic [2:0] DIV = 3'b100;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   alu_control;
   logic [W-1:0] src_a, src_b, hi, lo;
   logic         busy, done, div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
      logic         exp_dz;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Arithmetic reference: plain multiply, divide and modulo on wide integers.
   function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] h,
                                     output logic [W-1:0] l, output logic dz);
      longint sa, sb, q, r;
      logic [2*W-1:0] p;
      dz = 1'b0;
      sa = 0; sb = 0;
`ifdef SIGNED_MULDIV_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
`endif
      if (op == MUL) begin
         p = 64'(sa * sb);
         h = p[2*W-1:W];
         l = p[W-1:0];
      end else if (b == '0) begin
         h  = a;
         l  = '1;
         dz = 1'b1;
      end else begin
         q = sa / sb;
         r = sa % sb;
         h = r[W-1:0];
         l = q[W-1:0];
      end
   endfunction

   // Starts one op and waits (bounded) for done; operands are scrambled after accept.
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n, output logic hold_ok,
                        output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
      logic [W-1:0] h0, l0;
      lat = -1; busy_n = 0; hold_ok = 1'b1; h = '0; l = '0; dz = 1'b0;
      @(negedge clk);
      start = 1'b1; alu_control = op; src_a = a; src_b = b;
      h0 = hi; l0 = lo;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start       = 1'b0;
            src_a       = $urandom;
            src_b       = $urandom;
            alu_control = 3'($urandom_range(7, 0));
         end
         if (busy) begin
            busy_n++;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
         end
         if (done) begin
            lat = k; h = hi; l = lo; dz = div_by_zero;
            break;
         end
      end
   endtask

   initial begin
      vec_t         tbl[12];
      int           lat, busy_n, n_done, done_at;
      logic         hold_ok, dz, e_dz, seen;
      logic [W-1:0] h, l, e_h, e_l;

      tbl[0]  = '{MUL, 32'd7,          32'd6,          32'h0,        32'h2A,       1'b0};
      tbl[2]  = '{DIV, 32'd100,        32'd7,          32'd2,        32'd14,       1'b0};
      tbl[3]  = '{DIV, 32'd5,          32'd0,          32'd5,        32'hFFFFFFFF, 1'b1};
      tbl[5]  = '{DIV, 32'hFFFFFFFF,   32'd1,          32'h0,        32'hFFFFFFFF, 1'b0};
      tbl[9]  = '{MUL, 32'd0,          32'h12345,      32'h0,        32'h0,        1'b0};
      tbl[10] = '{DIV, 32'd3,          32'd5,          32'd3,        32'd0,        1'b0};
`ifdef SIGNED_MULDIV_EN
      tbl[1]  = '{MUL, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h0,        32'h1,        1'b0};
      tbl[4]  = '{MUL, 32'h80000000,   32'd2,          32'hFFFFFFFF, 32'h0,        1'b0};
      tbl[6]  = '{DIV, 32'd7,          32'hFFFFFFFF,   32'h0,        32'hFFFFFFF9, 1'b0};
      tbl[7]  = '{DIV, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      tbl[8]  = '{DIV, 32'h80000000,   32'hFFFFFFFF,   32'h0,        32'h80000000, 1'b0};
      tbl[11] = '{MUL, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
`else
      tbl[1]  = '{MUL, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h1,        1'b0};
      tbl[4]  = '{MUL, 32'h80000000,   32'd2,          32'h1,        32'h0,        1'b0};
      tbl[6]  = '{DIV, 32'd7,          32'hFFFFFFFF,   32'd7,        32'h0,        1'b0};
      tbl[7]  = '{DIV, 32'hFFFFFFF9,   32'd2,          32'd1,        32'h7FFFFFFC, 1'b0};
      tbl[8]  = '{DIV, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h0,        1'b0};
      tbl[11] = '{MUL, 32'hFFFFFFFF,   32'd1,          32'h0,        32'hFFFFFFFF, 1'b0};
`endif

      rst = 1'b1; start = 1'b0; alu_control = 3'b000; src_a = '0; src_b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_hi", 64'(hi), 64'(0));
      check("reset_lo", 64'(lo), 64'(0));
      check("reset_dbz", 64'(div_by_zero), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, busy_n, hold_ok, h, l, dz);
         check($sformatf("tbl%0d_hi", i), 64'(h), 64'(tbl[i].exp_hi));
         check($sformatf("tbl%0d_lo", i), 64'(l), 64'(tbl[i].exp_lo));
         check($sformatf("tbl%0d_dbz", i), 64'(dz), 64'(tbl[i].exp_dz));
         check($sformatf("tbl%0d_latency", i), 64'(lat), tbl[i].exp_dz ? 64'(1) : 64'(W + 1));
         check($sformatf("tbl%0d_busy_cycles", i), 64'(busy_n), tbl[i].exp_dz ? 64'(0) : 64'(W));
         check($sformatf("tbl%0d_hilo_hold", i), 64'(hold_ok), 64'(1));
      end

      for (int i = 0; i < 40; i++) begin
         logic [2:0]   op;
         logic [W-1:0] a, b;
         op = ($urandom_range(1, 0) == 1) ? MUL : DIV;
         a  = $urandom;
         case ($urandom_range(3, 0))
            0:       b = '0;
            1:       b = W'($urandom_range(15, 1));
            default: b = $urandom;
         endcase
         ref_model(op, a, b, e_h, e_l, e_dz);
         do_op(op, a, b, lat, busy_n, hold_ok, h, l, dz);
         check($sformatf("rnd%0d_hi", i), 64'(h), 64'(e_h));
         check($sformatf("rnd%0d_lo", i), 64'(l), 64'(e_l));
         check($sformatf("rnd%0d_dbz", i), 64'(dz), 64'(e_dz));
         check($sformatf("rnd%0d_latency", i), 64'(lat), e_dz ? 64'(1) : 64'(W + 1));
      end

      // Second start during an in-flight DIV is dropped.
      @(negedge clk);
      start = 1'b1; alu_control = DIV; src_a = 32'd100; src_b = 32'd7;
      n_done = 0; done_at = -1; h = '0; l = '0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         start = (k == 10);
         if (k == 10) begin
            alu_control = MUL; src_a = 32'd3; src_b = 32'd3;
         end
         if (done) begin
            n_done++; done_at = k; h = hi; l = lo;
         end
      end
      check("busy_start_done_count", 64'(n_done), 64'(1));
      check("busy_start_done_time", 64'(done_at), 64'(W + 1));
      check("busy_start_hi", 64'(h), 64'(2));
      check("busy_start_lo", 64'(l), 64'(14));

      // Unsupported code in IDLE is ignored.
      @(negedge clk);
      start = 1'b1; alu_control = 3'b010; src_a = 32'd9; src_b = 32'd9;
      seen = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy || done) seen = 1'b1;
      end
      check("bad_code_activity", 64'(seen), 64'(0));
      check("bad_code_hi", 64'(hi), 64'(2));
      check("bad_code_lo", 64'(lo), 64'(14));

      // Reset in the middle of a MUL abandons it.
      @(negedge clk);
      start = 1'b1; alu_control = MUL; src_a = 32'd7; src_b = 32'd6;
      n_done = 0;
      for (int k = 1; k <= 56; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 15) rst = 1'b1;
         if (k == 16) begin
            check("midrst_busy", 64'(busy), 64'(0));
            check("midrst_hi", 64'(hi), 64'(0));
            check("midrst_lo", 64'(lo), 64'(0));
            rst = 1'b0;
         end
         if (done) n_done++;
      end
      check("midrst_no_done", 64'(n_done), 64'(0));

      do_op(MUL, 32'd2, 32'd3, lat, busy_n, hold_ok, h, l, dz);
      check("post_rst_lo", 64'(l), 64'(6));
      check("post_rst_hi", 64'(h), 64'(0));
      check("post_rst_latency", 64'(lat), 64'(W + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
